prefetch_fetch_unit: RTL and testbench
======================================

# prefetch_fetch_unit

Parametrised instruction-fetch front end for the RV32I core: owns the fetch PC, streams word addresses to the synchronous program ROM, and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue. The control unit consumes instructions through a valid/ready pair and steers control flow with a redirect strobe, which flushes the queue and kills the in-flight fetch. It replaces the single-register PC plus fetch-latch path between program memory and the instruction decoder.

## Interface
- XLEN, 32, instruction and PC width
- PADDR_W, 9, program memory word-address width
- DEPTH, 4, queue entries; power of two, ≥2; full throughput needs ≥3
- RESET_PC, 0, fetch PC after reset; low 2 bits must be 0
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PADDR_W  word address, equal to fetch_pc[PADDR_W+1:2]
- imem_rdata  in  XLEN  ROM data; valid in the cycle after the request
- redirect  in  1  control-flow change strobe
- redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored (forced 0)
- deq_ready  in  1  consumer takes the head entry
- inst_valid  out  1  queue non-empty
- inst_out  out  XLEN  head instruction; NOP (0x00000013) when inst_valid=0
- inst_pc  out  XLEN  PC of head instruction; 0 when empty
- inst_pc_link  out  XLEN  inst_pc+4, modulo 2^XLEN
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Registers: fetch_pc, inflight (non-killed request outstanding), kill, inflight_pc, queue (instr+pc per entry), rd/wr pointers, count.
- imem_req/imem_addr depend on registers only: imem_req = (count + inflight < DEPTH). Dequeues in the same cycle are not credited.
- On request: inflight_pc ← fetch_pc, fetch_pc ← fetch_pc+4 (wraps modulo 2^XLEN; program space wraps at 2^PADDR_W words through addr truncation), inflight ← 1.
- Response cycle (inflight=1): if kill=0 and redirect=0, push {imem_rdata, inflight_pc}; otherwise discard.
- Dequeue when inst_valid & deq_ready & ~redirect. Push and pop in the same cycle: count unchanged.
- Redirect (highest priority): queue flushed (count ← 0, pointers ← 0), fetch_pc ← {redirect_pc[XLEN-1:2],2'b00}, kill ← 1 if a request is issued this cycle, else 0; deq_ready ignored.
- FSM: RUN ↔ FLUSH. RUN→FLUSH on redirect; FLUSH lasts one cycle (stale response discarded, first request to target issued), then →RUN. Redirect during FLUSH restarts FLUSH with the newest target (last wins).
- Push never occurs when full; this is guaranteed by the credit rule. The bench asserts it.

## Timing
- Reset (async, immediate): fetch_pc=RESET_PC, count=0, inflight=0, kill=0, state=RUN, inst_valid=0, inst_out=NOP, inst_pc=0, inst_pc_link=4, imem_req=1, imem_addr=RESET_PC[PADDR_W+1:2].
- Request in cycle c → data on imem_rdata in c+1 → entry visible at head in c+2.
- First instruction after reset release: inst_valid in cycle 2.
- Redirect in cycle t: target request in t+1; target instruction at head in t+3.
- Steady state with DEPTH≥3 and deq_ready=1: one instruction per cycle.
- Reset asserted mid-operation: all queued and in-flight data is lost with no residual push.

## Structure
- fetch_pkg: NOP_INSTR=32'h00000013, INST_BYTES=4, fetch_state_t enum {RUN, FLUSH}.
- One sub-module, instr_queue: circular FIFO parametrised on width and DEPTH. It has push, pop, synchronous flush, head data, count and async reset. The top level holds PC, credit, kill and FSM logic.

## Test plan
- Reset release with RESET_PC=0, deq_ready=0: requests at addr 0,1,2,3, then imem_req=0. count reaches 4 and head is word 0 with inst_pc=0.
- ROM word k = 0x1000+k, deq_ready=1, DEPTH=4: inst_out 0x1000,0x1001,… one per cycle from cycle 2. inst_pc_link = inst_pc+4.
- Redirect to 0x40 while 3 entries are queued and a fetch is in flight: count=0 next cycle and the stale response is dropped. Head = word 16 with inst_pc=0x40 three cycles after redirect.
- Back-to-back redirects to 0x80 then 0x100: only 0x100 and its successors ever appear. No 0x80 entry is pushed.
- redirect_pc=0x43: fetch resumes at 0x40. Also, fetch_pc reaching 0x7FC with PADDR_W=9: imem_addr wraps 511→0 while inst_pc continues to 0x800.
- rst pulsed mid-stream, asynchronous to the clock edge: outputs return to reset values immediately. The fetch sequence restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

    // Canonical RV32I NOP (addi x0, x0, 0), presented when no instruction is available.
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    // Every RV32I instruction occupies one 4-byte word.
    localparam int          INST_BYTES = 4;

    // RUN streams sequentially; FLUSH is the single cycle spent after a redirect.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_queue.sv
// Circular FIFO holding fetched instruction/PC pairs for the fetch unit.
// The caller guarantees no push when full and no pop when empty.
module instr_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointer and occupancy bookkeeping; flush empties the queue and outranks push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates their visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to the
// synchronous program ROM, and buffers returned instructions in a prefetch queue.
// A redirect flushes the queue and kills the one request that may be in flight.
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               PADDR_W  = 9,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [PADDR_W-1:0]         imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       deq_ready,
    output logic                       inst_valid,
    output logic [XLEN-1:0]            inst_out,
    output logic [XLEN-1:0]            inst_pc,
    output logic [XLEN-1:0]            inst_pc_link,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int QW = 2 * XLEN;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   inflight_pc;
    logic              inflight;
    logic              kill;
    logic [XLEN-1:0]   redirect_target;
    logic              q_push;
    logic              q_pop;
    logic              q_flush;
    logic [QW-1:0]     q_head;
    logic [CW-1:0]     q_count;
    logic              unused_ok;

    // Credit rule: a request is only made when its response is sure to find a free slot.
    assign imem_req        = (int'(q_count) + int'(inflight)) < DEPTH;
    assign imem_addr       = fetch_pc[PADDR_W+1:2];
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Low PC bits and the address bits above the ROM window are intentionally dropped.
    assign unused_ok = ^{redirect_pc[1:0], fetch_pc[1:0], fetch_pc[XLEN-1:PADDR_W+2]};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus queue push/pop/flush strobes; a redirect always wins.
    always_comb begin
        state_next = state;
        q_push     = 1'b0;
        q_pop      = 1'b0;
        q_flush    = 1'b0;
        case (state)
            RUN:     state_next = redirect ? FLUSH : RUN;
            FLUSH:   state_next = redirect ? FLUSH : RUN;
            default: state_next = RUN;
        endcase
        q_flush = redirect;
        q_push  = inflight && !kill && !redirect && (state == RUN);
        q_pop   = inst_valid && deq_ready && !redirect;
    end

    // Fetch PC, in-flight tracking and kill flag for the request issued this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
        end else begin
            inflight <= imem_req;
            kill     <= redirect && imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_target;
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
            end
        end
    end

    instr_queue #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (q_push),
        .pop       (q_pop),
        .push_data ({imem_rdata, inflight_pc}),
        .head_data (q_head),
        .count     (q_count)
    );

    assign count        = q_count;
    assign inst_valid   = (q_count != '0);
    assign inst_out     = inst_valid ? q_head[QW-1:XLEN] : XLEN'(NOP_INSTR);
    assign inst_pc      = inst_valid ? q_head[XLEN-1:0]  : '0;
    assign inst_pc_link = inst_pc + XLEN'(INST_BYTES);

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Self-checking bench for prefetch_fetch_unit: directed timing steps followed by
// randomized consumer/redirect traffic checked against a program-order PC model.
module tb_prefetch_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          PADDR_W  = 9;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic                clk;
    logic                rst;
    logic                imem_req;
    logic [PADDR_W-1:0]  imem_addr;
    logic [XLEN-1:0]     imem_rdata;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;
    logic                deq_ready;
    logic                inst_valid;
    logic [XLEN-1:0]     inst_out;
    logic [XLEN-1:0]     inst_pc;
    logic [XLEN-1:0]     inst_pc_link;
    logic [2:0]          count;

    int          checks;
    int          errors;
    int          deq_total;
    logic [31:0] exp_pc;

    prefetch_fetch_unit #(
        .XLEN     (XLEN),
        .PADDR_W  (PADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .deq_ready    (deq_ready),
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .inst_pc_link (inst_pc_link),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word k holds 0x1000 + k.
    function automatic logic [31:0] rom_word(input logic [PADDR_W-1:0] a);
        return 32'h1000 + 32'(a);
    endfunction

    // Synchronous program ROM: data appears the cycle after the address.
    always @(posedge clk) imem_rdata <= rom_word(imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the program-order model, then move to the next negedge.
    task automatic applyStimulus(input logic rd, input logic redir, input logic [31:0] rpc);
        deq_ready   = rd;
        redirect    = redir;
        redirect_pc = rpc;
        if (redir) begin
            exp_pc = {rpc[31:2], 2'b00};
        end else if (inst_valid === 1'b1 && rd) begin
            checkOutput("deq_pc", inst_pc, exp_pc);
            checkOutput("deq_inst", inst_out, rom_word(exp_pc[PADDR_W+1:2]));
            checkOutput("deq_link", inst_pc_link, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            deq_total++;
        end
        checkOutput("count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd0);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_inst"}, inst_out, NOP);
        checkOutput({tag, "_pc"}, inst_pc, 32'd0);
        checkOutput({tag, "_link"}, inst_pc_link, 32'd4);
        checkOutput({tag, "_req"}, 32'(imem_req), 32'd1);
        checkOutput({tag, "_addr"}, 32'(imem_addr), 32'(RESET_PC[PADDR_W+1:2]));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        deq_total   = 0;
        exp_pc      = RESET_PC;
        rst         = 1'b1;
        deq_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        $display("[TB] start");

        repeat (2) @(negedge clk);
        checkResetValues("reset");

        // Fill with consumer stalled: requests 0..3, then the credit rule stops fetching.
        rst = 1'b0;
        checkOutput("fill_addr0", 32'(imem_addr), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("fill_addr1", 32'(imem_addr), 32'd1);
        checkOutput("fill_valid_c1", 32'(inst_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("first_valid_c2", 32'(inst_valid), 32'd1);
        checkOutput("first_pc", inst_pc, 32'h0);
        checkOutput("first_inst", inst_out, 32'h1000);
        checkOutput("fill_addr2", 32'(imem_addr), 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("fill_addr3", 32'(imem_addr), 32'd3);
        checkOutput("fill_count2", 32'(count), 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("fill_req_off", 32'(imem_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_req_off", 32'(imem_req), 32'd0);
        checkOutput("full_head_pc", inst_pc, 32'h0);

        // Pop one, let one fetch go in flight, then redirect with 3 queued.
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("pop_count", 32'(count), 32'd3);
        checkOutput("pop_head_pc", inst_pc, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("inflight_count", 32'(count), 32'd3);
        applyStimulus(1'b0, 1'b1, 32'h40);
        checkOutput("redir_count0", 32'(count), 32'd0);
        checkOutput("redir_req", 32'(imem_req), 32'd1);
        checkOutput("redir_addr", 32'(imem_addr), 32'd16);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_valid_t2", 32'(inst_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_valid_t3", 32'(inst_valid), 32'd1);
        checkOutput("redir_head_pc", inst_pc, 32'h40);
        checkOutput("redir_head_inst", inst_out, 32'h1010);
        checkOutput("redir_stale_drop", 32'(count), 32'd1);

        // Back-to-back redirects: last target wins, then one instruction per cycle.
        applyStimulus(1'b1, 1'b1, 32'h80);
        applyStimulus(1'b1, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("b2b_head_pc", inst_pc, 32'h100);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stream_valid", 32'(inst_valid), 32'd1);
            applyStimulus(1'b1, 1'b0, 32'h0);
        end

        // Unaligned target is forced to a word boundary.
        applyStimulus(1'b1, 1'b1, 32'h43);
        checkOutput("unaligned_addr", 32'(imem_addr), 32'd16);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("unaligned_pc", inst_pc, 32'h40);

        // Program-space wrap: word address 511 -> 0 while the PC keeps counting.
        applyStimulus(1'b1, 1'b1, 32'h7F0);
        checkOutput("wrap_addr_start", 32'(imem_addr), 32'h1FC);
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap_addr_zero", 32'(imem_addr), 32'd0);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap_pc_past", 32'(exp_pc > 32'h800), 32'd1);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2 rst = 1'b1;
        #1 checkResetValues("async_rst");
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = RESET_PC;
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("restart_valid", 32'(inst_valid), 32'd1);
        checkOutput("restart_pc", inst_pc, RESET_PC);

        // Randomized consumer stalls and redirects against the program-order model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0),
                          32'($urandom_range(0, 32'hFFF)));
        end
        checkOutput("progress", 32'(deq_total >= 60), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
